// File: rtl/solo_squash_input_cond_pkg.sv
// Channel indices and default parameter values shared by the input conditioning block.
// Channel 0 is always the external reset button; the down/up keys are the autorepeat candidates.
package solo_squash_input_cond_pkg;

    localparam int CH_EXT_RESET = 0;
    localparam int CH_PAUSE     = 1;
    localparam int CH_NEW_GAME  = 2;
    localparam int CH_DOWN      = 3;
    localparam int CH_UP        = 4;

    localparam int         DEF_N_BTN         = 5;
    localparam int         DEF_SYNC_STAGES   = 2;
    localparam int         DEF_DEB_CYCLES    = 250000;
    localparam int         DEF_CNT_W         = 18;
    localparam logic [4:0] DEF_REPEAT_MASK   = 5'b11000;
    localparam int         DEF_REPEAT_DELAY  = 12500000;
    localparam int         DEF_REPEAT_PERIOD = 2500000;

endpackage

// File: rtl/solo_squash_input_cond_debounce_chan.sv
// Purpose: synchroniser, debounce counter and press/release pulses for one active-low input.
// Latency: SYNC_STAGES+DEB_CYCLES clocks from raw edge to btn_n change; pulses coincide with it.
// Backpressure: none, free-running per channel.
module input_debounce_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic btn_n,
    output logic press_pulse,
    output logic rel_pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync        <= '1;
            btn_n       <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], raw_n};
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (s == btn_n) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                btn_n       <= s;
                cnt         <= '0;
                press_pulse <= ~s;
                rel_pulse   <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/solo_squash_input_cond.sv
// Purpose: conditions raw active-low pads (sync, debounce, pulses, settle gate, clean design_reset); INPUT_COND_AUTOREPEAT_EN adds key autorepeat.
// Latency: SYNC_STAGES+DEB_CYCLES clocks per edge; design_reset asserts in 1 clock, releases 2 clocks after request drops.
// Backpressure: none; outputs are level/pulse signals with no handshake.
module solo_squash_input_cond
    import solo_squash_input_cond_pkg::*;
#(
    parameter int                 N_BTN         = DEF_N_BTN,
    parameter int                 SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int                 DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int                 CNT_W         = DEF_CNT_W,
    parameter logic [N_BTN-1:0]   REPEAT_MASK   = N_BTN'(DEF_REPEAT_MASK),
    parameter int                 REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int                 REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sys_rst,
    input  logic [N_BTN-1:0] raw_n,
    output logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             inputs_valid,
    output logic             design_reset
);

    localparam int SETTLE   = SYNC_STAGES + DEB_CYCLES;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic [N_BTN-1:0]    chan_press;
    logic [N_BTN-1:0]    chan_rel;
    logic [N_BTN-1:0]    press_all;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [1:0]          rst_sh;
    logic                req;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        input_debounce_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw_n       (raw_n[i]),
            .btn_n       (btn_n[i]),
            .press_pulse (chan_press[i]),
            .rel_pulse   (chan_rel[i])
        );
    end

    // Settle window covers the worst-case time for pad levels to propagate through debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt   <= '0;
            inputs_valid <= 1'b0;
        end else if (!inputs_valid) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SETTLE_W'(SETTLE - 1)) begin
                inputs_valid <= 1'b1;
            end
        end
    end

    assign req = sys_rst | ~btn_n[CH_EXT_RESET] | ~inputs_valid;

    // A request loads both stages so even a one-cycle request holds reset for two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sh <= 2'b11;
        end else if (req) begin
            rst_sh <= 2'b11;
        end else begin
            rst_sh <= {rst_sh[0], 1'b0};
        end
    end

    assign design_reset = rst_sh[1];

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [N_BTN-1:0] rpt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_rpt
        if (REPEAT_MASK[i]) begin : g_on
            logic [RPT_W-1:0] rcnt;
            logic             first;
            logic             rpt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rcnt  <= '0;
                    first <= 1'b1;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if (btn_n[i]) begin
                        rcnt  <= '0;
                        first <= 1'b1;
                    end else if (rcnt == (first ? RPT_W'(REPEAT_DELAY - 1)
                                                : RPT_W'(REPEAT_PERIOD - 1))) begin
                        rcnt  <= '0;
                        first <= 1'b0;
                        rpt_q <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
            end

            assign rpt[i] = rpt_q;
        end else begin : g_off
            assign rpt[i] = 1'b0;
        end
    end

    // A repeat landing on the release edge is dropped.
    assign press_all = chan_press | (rpt & ~btn_n);
`else
    assign press_all = chan_press;
`endif

    assign btn_press   = press_all & {N_BTN{inputs_valid}};
    assign btn_release = chan_rel  & {N_BTN{inputs_valid}};

endmodule

// File: tb/tb_solo_squash_input_cond.sv
// Scoreboard bench for solo_squash_input_cond with short debounce/repeat timings.
module tb_solo_squash_input_cond;
    import solo_squash_input_cond_pkg::*;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sys_rst = 1'b0;
    logic [N-1:0] raw_n = '1;
    logic [N-1:0] btn_n, btn_press, btn_release;
    logic         inputs_valid, design_reset;

    solo_squash_input_cond #(
        .N_BTN         (N),
        .SYNC_STAGES   (2),
        .DEB_CYCLES    (16),
        .CNT_W         (5),
        .REPEAT_MASK   (5'b11000),
        .REPEAT_DELAY  (40),
        .REPEAT_PERIOD (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sys_rst      (sys_rst),
        .raw_n        (raw_n),
        .btn_n        (btn_n),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .inputs_valid (inputs_valid),
        .design_reset (design_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [16:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   press_seen[N];
    int   rel_seen[N];
    int   exp_press[N];
    int   exp_rel[N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, act, want, cyc);
        end
    endtask

    function automatic logic [16:0] obs();
        return {btn_n, btn_press, btn_release, inputs_valid, design_reset};
    endfunction

    function automatic logic [16:0] st(input logic [4:0] b, input logic [4:0] p,
                                       input logic [4:0] r, input logic v, input logic d);
        return {b, p, r, v, d};
    endfunction

    task automatic expect_at(input int c, input string tag, input logic [16:0] v);
        exp_t e;
        int   k;
        e = '{c, v, tag};
        k = sb.size();
        while (k > 0 && sb[k-1].cyc > c) k--;
        sb.insert(k, e);
    endtask

    task automatic wait_until(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic check_counts(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_press%0d", tag, i), press_seen[i], exp_press[i]);
            check($sformatf("%s_rel%0d", tag, i), rel_seen[i], exp_rel[i]);
        end
    endtask

    task automatic expect_startup(input string tag);
        expect_at(1,  {tag, "_c1"},  st(5'h1f, 5'h00, 5'h00, 1'b0, 1'b1));
        expect_at(17, {tag, "_c17"}, st(5'h1f, 5'h00, 5'h00, 1'b0, 1'b1));
        expect_at(18, {tag, "_c18"}, st(5'h1f, 5'h00, 5'h00, 1'b1, 1'b1));
        expect_at(19, {tag, "_c19"}, st(5'h1f, 5'h00, 5'h00, 1'b1, 1'b1));
        expect_at(20, {tag, "_c20"}, st(5'h1f, 5'h00, 5'h00, 1'b1, 1'b0));
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                press_seen[i] = press_seen[i] + int'(btn_press[i]);
                rel_seen[i]   = rel_seen[i] + int'(btn_release[i]);
            end
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) check({e.tag, "_missed"}, cyc, e.cyc);
                else             check(e.tag, obs(), e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        n_err++;
        n_chk++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            press_seen[i] = 0; rel_seen[i] = 0; exp_press[i] = 0; exp_rel[i] = 0;
        end

        // Reset state while rst_n is held low
        repeat (3) @(negedge clk);
        check("rst_state", obs(), st(5'h1f, 5'h00, 5'h00, 1'b0, 1'b1));

        // Startup settle with all inputs released
        rst_n = 1'b1;
        expect_startup("p1");
        wait_until(25);
        check_counts("p1");

        // Held press on channel 3, then release
        expect_at(47, "p2_pre",  st(5'h1f,    5'h00,    5'h00, 1'b1, 1'b0));
        expect_at(48, "p2_acc",  st(5'b10111, 5'b01000, 5'h00, 1'b1, 1'b0));
        expect_at(49, "p2_post", st(5'b10111, 5'h00,    5'h00, 1'b1, 1'b0));
        expect_at(77, "p2_rpre", st(5'b10111, 5'h00,    5'h00, 1'b1, 1'b0));
        expect_at(78, "p2_racc", st(5'h1f,    5'h00, 5'b01000, 1'b1, 1'b0));
        exp_press[3]++;
        exp_rel[3]++;
        wait_until(30);
        raw_n[3] = 1'b0;
        wait_until(60);
        raw_n[3] = 1'b1;
        wait_until(85);
        check_counts("p2");

        // 10-cycle glitch on channel 1 is rejected
        expect_at(108, "p3_a", st(5'h1f, 5'h00, 5'h00, 1'b1, 1'b0));
        expect_at(125, "p3_b", st(5'h1f, 5'h00, 5'h00, 1'b1, 1'b0));
        wait_until(90);
        raw_n[1] = 1'b0;
        wait_until(100);
        raw_n[1] = 1'b1;
        wait_until(126);
        check_counts("p3");

        // External reset button, then a one-cycle sys_rst
        expect_at(147, "p4_pre",   st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b0));
        expect_at(148, "p4_acc",   st(5'b11110, 5'b00001, 5'h00,    1'b1, 1'b0));
        expect_at(149, "p4_drst",  st(5'b11110, 5'h00,    5'h00,    1'b1, 1'b1));
        expect_at(177, "p4_hold",  st(5'b11110, 5'h00,    5'h00,    1'b1, 1'b1));
        expect_at(178, "p4_rel",   st(5'h1f,    5'h00,    5'b00001, 1'b1, 1'b1));
        expect_at(179, "p4_tail",  st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b1));
        expect_at(180, "p4_clr",   st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b0));
        expect_at(190, "p4_sr0",   st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b0));
        expect_at(191, "p4_sr1",   st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b1));
        expect_at(192, "p4_sr2",   st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b1));
        expect_at(193, "p4_sr3",   st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b0));
        exp_press[0]++;
        exp_rel[0]++;
        wait_until(130);
        raw_n[0] = 1'b0;
        wait_until(160);
        raw_n[0] = 1'b1;
        wait_until(190);
        sys_rst = 1'b1;
        wait_until(191);
        sys_rst = 1'b0;
        wait_until(195);
        check_counts("p4");

        // Simultaneous presses on channels 2 and 4
        expect_at(217, "p5_pre",  st(5'h1f,    5'h00,    5'h00,    1'b1, 1'b0));
        expect_at(218, "p5_acc",  st(5'b01011, 5'b10100, 5'h00,    1'b1, 1'b0));
        expect_at(219, "p5_post", st(5'b01011, 5'h00,    5'h00,    1'b1, 1'b0));
        expect_at(248, "p5_rel",  st(5'h1f,    5'h00,    5'b10100, 1'b1, 1'b0));
        exp_press[2]++; exp_press[4]++;
        exp_rel[2]++;   exp_rel[4]++;
        wait_until(200);
        raw_n[2] = 1'b0;
        raw_n[4] = 1'b0;
        wait_until(230);
        raw_n[2] = 1'b1;
        raw_n[4] = 1'b1;
        wait_until(255);
        check_counts("p5");

        // rst_n pulse in the middle of a debounce window
        wait_until(260);
        raw_n[4] = 1'b0;
        wait_until(270);
        check("p5_sb_empty", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        check("p5_rst_async", obs(), st(5'h1f, 5'h00, 5'h00, 1'b0, 1'b1));
        raw_n[4] = 1'b1;
        repeat (2) @(negedge clk);
        check("p5_rst_hold", obs(), st(5'h1f, 5'h00, 5'h00, 1'b0, 1'b1));
        rst_n = 1'b1;
        expect_startup("p5r");
        wait_until(25);
        check_counts("p5r");

        // Channels 2 and 4 held 100 cycles: only channel 4 may autorepeat
        expect_at(47, "p6_pre", st(5'h1f,    5'h00,    5'h00, 1'b1, 1'b0));
        expect_at(48, "p6_acc", st(5'b01011, 5'b10100, 5'h00, 1'b1, 1'b0));
        exp_press[2]++; exp_press[4]++;
        for (int k = 0; k < 6; k++) begin
            expect_at(87 + 10 * k, "p6_gap", st(5'b01011, 5'h00, 5'h00, 1'b1, 1'b0));
`ifdef INPUT_COND_AUTOREPEAT_EN
            expect_at(88 + 10 * k, "p6_rep", st(5'b01011, 5'b10000, 5'h00, 1'b1, 1'b0));
            exp_press[4]++;
`else
            expect_at(88 + 10 * k, "p6_norep", st(5'b01011, 5'h00, 5'h00, 1'b1, 1'b0));
`endif
        end
        expect_at(148, "p6_rel", st(5'h1f, 5'h00, 5'b10100, 1'b1, 1'b0));
        exp_rel[2]++; exp_rel[4]++;
        wait_until(30);
        raw_n[2] = 1'b0;
        raw_n[4] = 1'b0;
        wait_until(130);
        raw_n[2] = 1'b1;
        raw_n[4] = 1'b1;
        wait_until(160);
        check_counts("p6");
        check("p6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
